// File: rtl/stream_mux_n.sv
// stream_mux_n: N-to-1 registered stream mux with fixed-select or round-robin grant
module stream_mux_n #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = 8,
  parameter int MODE = 0,
  localparam int SELW = CHANNELS > 2 ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SELW-1:0]           sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SELW-1:0]           out_chan
);
  logic load_en, gv, rr_v, xfer;
  logic [SELW-1:0] g, rr_g, last, c;
  logic [WIDTH-1:0] ch_data [CHANNELS];
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end
  assign load_en = !out_valid || out_ready;
  // Scan downward so the candidate closest after last is written last and wins
  always_comb begin
    rr_g = '0;
    rr_v = 1'b0;
    c = '0;
    for (int k = CHANNELS; k >= 1; k--) begin
      c = SELW'((int'(last) + k) % CHANNELS);
      if (in_valid[c]) begin
        rr_g = c;
        rr_v = 1'b1;
      end
    end
  end
  assign g = MODE == 0 ? sel : rr_g;
  assign gv = MODE == 0 ? int'(sel) < CHANNELS : rr_v;
  assign in_ready = (gv && load_en && !rst) ? CHANNELS'(1) << g : '0;
  assign xfer = |(in_ready & in_valid);
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_chan <= '0;
      last <= SELW'(CHANNELS - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data <= ch_data[g];
      out_chan <= g;
      last <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: fixed-select and round-robin instances checked against a queue-free behavioural model
module tb_stream_mux_n;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, out_ready;
  logic [1:0] sel;
  logic [31:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] rdy0, rdy1;
  logic [7:0] od0, od1;
  logic ov0, ov1;
  logic [1:0] oc0, oc1;
  int checks = 0, passes = 0;
  logic mv [2];
  logic [7:0] md [2];
  logic [1:0] mc [2];
  int np;
  logic [7:0] held;
  int seq [6] = '{0, 1, 2, 3, 0, 1};

  stream_mux_n #(.CHANNELS(4), .WIDTH(8), .MODE(0)) d0 (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_chan(oc0));
  stream_mux_n #(.CHANNELS(4), .WIDTH(8), .MODE(1)) d1 (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_chan(oc1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: check combinational ready, advance the model, check registered outputs
  task automatic cycle();
    logic [3:0] er [2];
    logic [3:0] xr;
    int g;
    bit gv;
    #1;
    for (int m = 0; m < 2; m++) begin
      gv = 0;
      g = 0;
      if (m == 0) begin
        gv = 1;
        g = int'(sel);
      end else begin
        for (int k = 0; k < 4; k++)
          if (!gv && in_valid[(np + k) % 4]) begin
            gv = 1;
            g = (np + k) % 4;
          end
      end
      er[m] = (!rst && gv && (!mv[m] || out_ready)) ? 4'(1 << g) : 4'd0;
    end
    chk("in_ready0", 32'(rdy0), 32'(er[0]));
    chk("in_ready1", 32'(rdy1), 32'(er[1]));
    for (int m = 0; m < 2; m++) begin
      xr = er[m] & in_valid;
      if (rst) begin
        mv[m] = 0;
        md[m] = 0;
        mc[m] = 0;
        if (m == 1) np = 0;
      end else if (xr != 0) begin
        for (int k = 0; k < 4; k++) if (xr[k]) g = k;
        mv[m] = 1;
        md[m] = in_data[g*8 +: 8];
        mc[m] = 2'(g);
        if (m == 1) np = (g + 1) % 4;
      end else if (out_ready) begin
        mv[m] = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid0", 32'(ov0), 32'(mv[0]));
    chk("out_data0", 32'(od0), 32'(md[0]));
    chk("out_chan0", 32'(oc0), 32'(mc[0]));
    chk("out_valid1", 32'(ov1), 32'(mv[1]));
    chk("out_data1", 32'(od1), 32'(md[1]));
    chk("out_chan1", 32'(oc1), 32'(mc[1]));
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mv[m] = 0;
      md[m] = 0;
      mc[m] = 0;
    end
    np = 0;
    rst = 1; sel = 0; in_data = 0; in_valid = 0; out_ready = 1;
    cycle();
    cycle();
    chk("reset_valid", 32'(ov1), 32'd0);
    rst = 0; sel = 2; in_valid = 4'hF; in_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    cycle();
    chk("sel2_data", 32'(od0), 32'hA5);
    chk("sel2_chan", 32'(oc0), 32'd2);
    chk("sel2_valid", 32'(ov0), 32'd1);
    sel = 1;
    cycle();
    chk("sel1_nogap", 32'(od0), 32'h22);
    chk("sel1_valid", 32'(ov0), 32'd1);
    rst = 1;
    cycle();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("rr_seq", 32'(oc1), 32'(seq[i]));
      chk("rr_seq_valid", 32'(ov1), 32'd1);
    end
    rst = 1;
    cycle();
    rst = 0; in_valid = 4'h8;
    cycle();
    chk("wrap_a", 32'(oc1), 32'd3);
    in_valid = 4'h9;
    cycle();
    chk("wrap_b", 32'(oc1), 32'd0);
    cycle();
    chk("wrap_c", 32'(oc1), 32'd3);
    out_ready = 0;
    held = od1;
    for (int i = 0; i < 3; i++) begin
      in_data = $urandom;
      in_valid = 4'($urandom);
      sel = 2'($urandom);
      cycle();
      chk("stall_data", 32'(od1), 32'(held));
      chk("stall_ready", 32'(rdy1), 32'd0);
    end
    out_ready = 1; in_valid = 0;
    cycle();
    chk("drain_valid", 32'(ov1), 32'd0);
    in_valid = 4'h1; in_data = 32'h0000_003C; out_ready = 0;
    cycle();
    chk("hold_3c", 32'(od1), 32'h3C);
    rst = 1;
    cycle();
    chk("rst_valid", 32'(ov1), 32'd0);
    chk("rst_data", 32'(od1), 32'd0);
    rst = 0; in_valid = 4'hF; out_ready = 1;
    cycle();
    chk("restart_ch0", 32'(oc1), 32'd0);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      sel = 2'($urandom);
      in_data = $urandom;
      in_valid = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
